serial_paralelo_align: RTL

- Parametrised successor to the team's 8-bit serial-to-parallel converter.
- Deserialises an MSB-first bit stream at clk_32f into WIDTH-bit words, hunts for the COMMA pattern at any bit offset, and qualifies alignment with LOCK_COUNT consecutive word-aligned commas before asserting active.
- Detects loss of alignment when commas stop arriving, then re-hunts.
- Sits between the serial link receiver and the parallel-domain demux.

---
 rtl/serial_paralelo_align_pkg.sv | 19 +
 rtl/serial_paralelo_align_comma_lock_fsm.sv | 107 ++++++++++
 rtl/serial_paralelo_align.sv | 116 +++++++++++
 3 files changed

// File: rtl/serial_paralelo_align_pkg.sv
// Shared types and constants for the serial-to-parallel aligner.
package serial_paralelo_align_pkg;

    // Alignment FSM states; encoding 2'd3 is unused and recovers to HUNT.
    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    // Default comma pattern for the 8-bit link.
    localparam logic [7:0] DEFAULT_COMMA = 8'hBC;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/serial_paralelo_align_comma_lock_fsm.sv
// Alignment FSM: hunts, qualifies and monitors comma alignment.
module serial_paralelo_align_comma_lock_fsm
    import serial_paralelo_align_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MAX_GAP    = 16
) (
    input  logic   clk_32f,
    input  logic   reset,
    input  logic   boundary,
    input  logic   is_comma,
    input  logic   hunt_hit,
    output state_e state,
    output logic   locked_nxt_c,
    output logic   present_c,
    output logic   comma_pulse_c
);

    localparam int unsigned CNT_W = cnt_width(LOCK_COUNT);
    localparam int unsigned GAP_W = cnt_width(MAX_GAP);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   comma_cnt_q, comma_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   comma_inc;
    logic [GAP_W-1:0]   gap_inc;
    logic               comma_last;
    logic               gap_last;

    // Saturating increments and "this word reaches the limit" flags.
    assign comma_inc  = (comma_cnt_q == {CNT_W{1'b1}}) ? comma_cnt_q : comma_cnt_q + CNT_W'(1);
    assign gap_inc    = (gap_cnt_q == {GAP_W{1'b1}}) ? gap_cnt_q : gap_cnt_q + GAP_W'(1);
    assign comma_last = ({1'b0, comma_cnt_q} + (CNT_W+1)'(1)) >= (CNT_W+1)'(LOCK_COUNT);
    assign gap_last   = (MAX_GAP != 0) &&
                        (({1'b0, gap_cnt_q} + (GAP_W+1)'(1)) == (GAP_W+1)'(MAX_GAP));

    assign state = state_q;

    // State and counter registers.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= ST_HUNT;
            comma_cnt_q <= '0;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    // Next-state logic and per-boundary strobes for the output stage.
    always_comb begin
        state_d       = state_q;
        comma_cnt_d   = comma_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        present_c     = 1'b0;
        comma_pulse_c = 1'b0;
        locked_nxt_c  = 1'b0;
        case (state_q)
            ST_HUNT: begin
                if (hunt_hit) begin
                    comma_cnt_d = CNT_W'(1);
                    gap_cnt_d   = '0;
                    state_d     = (LOCK_COUNT == 1) ? ST_LOCKED : ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_inc;
                        if (comma_last) begin
                            state_d   = ST_LOCKED;
                            gap_cnt_d = '0;
                        end
                    end else begin
                        state_d     = ST_HUNT;
                        comma_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_pulse_c = 1'b1;
                        gap_cnt_d     = '0;
                    end else begin
                        gap_cnt_d = gap_inc;
                        if (gap_last) begin
                            state_d     = ST_HUNT;
                            comma_cnt_d = '0;
                        end else begin
                            present_c = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d     = ST_HUNT;
                comma_cnt_d = '0;
                gap_cnt_d   = '0;
            end
        endcase
        locked_nxt_c = (state_d == ST_LOCKED);
    end

endmodule

// File: rtl/serial_paralelo_align.sv
// MSB-first serial-to-parallel converter with comma-based word alignment.
module serial_paralelo_align
    import serial_paralelo_align_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEFAULT_COMMA),
    parameter int unsigned      LOCK_COUNT = 4,
    parameter int unsigned      MAX_GAP    = 16
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in_SP,
    output logic [WIDTH-1:0] data_out_SP,
    output logic             valid_SP,
    output logic             active,
    output logic             comma_det
);

    localparam int unsigned BIT_W = $clog2(WIDTH + 1);

    if (WIDTH < 4) begin : g_bad_width
        $error("serial_paralelo_align: WIDTH must be at least 4");
    end
    if (COMMA == '0) begin : g_bad_comma
        $error("serial_paralelo_align: COMMA must be non-zero");
    end
    if (LOCK_COUNT < 1) begin : g_bad_lock
        $error("serial_paralelo_align: LOCK_COUNT must be at least 1");
    end

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [BIT_W-1:0] bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             active_q, active_d;
    logic             comma_det_q, comma_det_d;

    state_e           state;
    logic             boundary;
    logic             is_comma;
    logic             hunt_hit;
    logic             locked_nxt_c;
    logic             present_c;
    logic             comma_pulse_c;

    assign boundary = (bitcnt_q == BIT_W'(WIDTH));
    assign is_comma = (sh_q == COMMA);
    assign hunt_hit = (state == ST_HUNT) && is_comma;

    serial_paralelo_align_comma_lock_fsm #(
        .LOCK_COUNT (LOCK_COUNT),
        .MAX_GAP    (MAX_GAP)
    ) u_fsm (
        .clk_32f       (clk_32f),
        .reset         (reset),
        .boundary      (boundary),
        .is_comma      (is_comma),
        .hunt_hit      (hunt_hit),
        .state         (state),
        .locked_nxt_c  (locked_nxt_c),
        .present_c     (present_c),
        .comma_pulse_c (comma_pulse_c)
    );

    // Shift register and bit counter; the counter restarts on a hunt hit or a boundary.
    always_comb begin
        sh_d     = {sh_q[WIDTH-2:0], data_in_SP};
        bitcnt_d = bitcnt_q;
        if (boundary || hunt_hit) begin
            bitcnt_d = BIT_W'(1);
        end else if (state != ST_HUNT) begin
            bitcnt_d = bitcnt_q + BIT_W'(1);
        end
    end

    // Output stage: present data words, blank on commas and whenever not locked.
    always_comb begin
        data_out_d  = data_out_q;
        valid_d     = valid_q;
        active_d    = locked_nxt_c;
        comma_det_d = comma_pulse_c;
        if (present_c) begin
            data_out_d = sh_q;
            valid_d    = 1'b1;
        end
        if (comma_pulse_c || !locked_nxt_c) begin
            data_out_d = '0;
            valid_d    = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            sh_q        <= '0;
            bitcnt_q    <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
            comma_det_q <= 1'b0;
        end else begin
            sh_q        <= sh_d;
            bitcnt_q    <= bitcnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            active_q    <= active_d;
            comma_det_q <= comma_det_d;
        end
    end

    assign data_out_SP = data_out_q;
    assign valid_SP    = valid_q;
    assign active      = active_q;
    assign comma_det   = comma_det_q;

endmodule
